// File: rtl/race_pkg.sv
// Shared types and constants for the race referee and its helpers.
package race_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCountdown,
        StGreen,
        StRed,
        StDone
    } state_e;

    localparam int unsigned LfsrW = 8;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [LfsrW-1:0] LfsrTaps = 8'hB8;

    localparam int unsigned DefPosW = 4;

    // Width needed to index n cars; never less than one bit
    function automatic int unsigned car_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/race_referee_if.sv
// Bus between the referee and the car units: shared light, limits, reset, car status.
interface race_referee_if
    import race_pkg::*;
#(
    parameter int unsigned N_CARS = 2,
    parameter int unsigned POS_W  = DefPosW
);
    logic [N_CARS*POS_W-1:0] car_position;
    logic [N_CARS-1:0]       car_finished;
    logic [POS_W-1:0]        max_clicks;
    logic [POS_W-1:0]        max_steps;
    logic                    car_rst;
    logic                    enable;
    logic                    red;

    modport master (
        input  car_position,
        input  car_finished,
        output max_clicks,
        output max_steps,
        output car_rst,
        output enable,
        output red
    );

    modport slave (
        output car_position,
        output car_finished,
        input  max_clicks,
        input  max_steps,
        input  car_rst,
        input  enable,
        input  red
    );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; entropy comes from when the players press start.
module lfsr8
    import race_pkg::*;
#(
    parameter logic [LfsrW-1:0] Seed = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    output logic [LfsrW-1:0] value
);

    // Shift every cycle; a non-zero seed keeps the register out of the lock-up state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= Seed;
        end else begin
            value <= {value[LfsrW-2:0], ^(value & LfsrTaps)};
        end
    end

endmodule

// File: rtl/race_referee.sv
// Race control: countdown, random green / fixed red light phases, winner and DQ judging.
module race_referee
    import race_pkg::*;
#(
    parameter int unsigned N_CARS      = 2,
    parameter int unsigned POS_W       = DefPosW,
    parameter int unsigned RED_TICKS   = 3,
    parameter int unsigned MIN_GREEN   = 2,
    parameter int unsigned GREEN_MASK  = 7,
    parameter int unsigned COUNT_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic [POS_W-1:0]  cfg_max_clicks,
    input  logic [POS_W-1:0]  cfg_max_steps,
    race_referee_if.master    cars,
    output logic [1:0]        countdown,
    output logic              race_done,
    output logic              winner_valid,
    output logic [2:0]        winner_id,
    output logic [N_CARS-1:0] dq_mask
);

    localparam int unsigned      IdW       = car_id_w(N_CARS);
    localparam logic [LfsrW-1:0] GreenMask = LfsrW'(GREEN_MASK);

    state_e            state;
    logic              start_q;
    logic [3:0]        cnt;
    logic [3:0]        timer;
    logic [3:0]        green_len;
    logic [LfsrW-1:0]  lfsr_value;
    logic [POS_W-1:0]  max_clicks_q;
    logic [POS_W-1:0]  max_steps_q;
    logic              car_rst_q;
    logic              enable_q;
    logic              red_q;
    logic              start_rise;
    logic [N_CARS-1:0] new_arr;
    logic [N_CARS-1:0] new_dq;
    logic              win_found;
    logic [IdW-1:0]    win_id;
    logic              all_dq;

    lfsr8 #(
        .Seed (8'h01)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign start_rise = start & ~start_q;
    assign green_len  = 4'(32'(MIN_GREEN) + 32'(lfsr_value & GreenMask));
    assign all_dq     = &(dq_mask | new_dq);
    // Saturate for the 2-bit display in case COUNT_TICKS is raised
    assign countdown  = (cnt > 4'd3) ? 2'd3 : cnt[1:0];

    assign cars.max_clicks = max_clicks_q;
    assign cars.max_steps  = max_steps_q;
    assign cars.car_rst    = car_rst_q;
    assign cars.enable     = enable_q;
    assign cars.red        = red_q;

    // Classify this cycle's finishers; already-disqualified cars cannot arrive later
    always_comb begin
        new_arr   = '0;
        new_dq    = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < int'(N_CARS); i++) begin
            if (cars.car_finished[i] && !dq_mask[i]) begin
                if (cars.car_position[i*POS_W +: POS_W] >= max_steps_q) begin
                    new_arr[i] = 1'b1;
                end else begin
                    new_dq[i] = 1'b1;
                end
            end
        end
        // Descending scan so the lowest arrived index wins ties
        for (int i = int'(N_CARS) - 1; i >= 0; i--) begin
            if (new_arr[i]) begin
                win_found = 1'b1;
                win_id    = IdW'(i);
            end
        end
    end

    // Race FSM with registered lights, limits and results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            start_q      <= 1'b0;
            cnt          <= '0;
            timer        <= '0;
            max_clicks_q <= '0;
            max_steps_q  <= '0;
            car_rst_q    <= 1'b0;
            enable_q     <= 1'b0;
            red_q        <= 1'b0;
            race_done    <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= '0;
            dq_mask      <= '0;
        end else begin
            start_q   <= start;
            car_rst_q <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    enable_q <= 1'b0;
                    red_q    <= 1'b1;
                    if (start_rise) begin
                        max_clicks_q <= cfg_max_clicks;
                        max_steps_q  <= cfg_max_steps;
                        car_rst_q    <= 1'b1;
                        cnt          <= 4'(COUNT_TICKS);
                        race_done    <= 1'b0;
                        winner_valid <= 1'b0;
                        winner_id    <= '0;
                        dq_mask      <= '0;
                        state        <= StCountdown;
                    end
                end
                StCountdown: begin
                    if (tick) begin
                        cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                        if (cnt <= 4'd1) begin
                            state    <= StGreen;
                            timer    <= green_len;
                            enable_q <= 1'b1;
                            red_q    <= 1'b0;
                        end
                    end
                end
                StGreen, StRed: begin
                    dq_mask <= dq_mask | new_dq;
                    if (win_found) begin
                        state        <= StDone;
                        race_done    <= 1'b1;
                        winner_valid <= 1'b1;
                        winner_id    <= 3'(win_id);
                        enable_q     <= 1'b0;
                        red_q        <= 1'b1;
                    end else if (all_dq) begin
                        state        <= StDone;
                        race_done    <= 1'b1;
                        winner_valid <= 1'b0;
                        enable_q     <= 1'b0;
                        red_q        <= 1'b1;
                    end else if (tick) begin
                        if (timer <= 4'd1) begin
                            if (state == StGreen) begin
                                state <= StRed;
                                timer <= 4'(RED_TICKS);
                                red_q <= 1'b1;
                            end else begin
                                state <= StGreen;
                                timer <= green_len;
                                red_q <= 1'b0;
                            end
                        end else begin
                            timer <= timer - 4'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
